// File: rtl/mpt_pkg.sv
// Shared memory-protection-table types used by the MPT walker pipeline stages.
package mpt_pkg;

  localparam int MPTW_ID_W = 4;

  typedef enum logic [1:0] {
    ACCESS_READ    = 2'd0,
    ACCESS_WRITE   = 2'd1,
    ACCESS_EXECUTE = 2'd2
  } access_type_t;

  typedef enum logic [3:0] {
    MPT_MODE_BARE    = 4'd0,
    MPT_MODE_SMMPT34 = 4'd1,
    MPT_MODE_SMMPT43 = 4'd2,
    MPT_MODE_SMMPT52 = 4'd3,
    MPT_MODE_SMMPT64 = 4'd4
  } mpt_mode_t;

  typedef struct packed {
    mpt_mode_t   mode;
    logic [43:0] ppn;
  } mmpt_t;

  typedef enum logic [2:0] {
    MPT_WALKING_START = 3'd0,
    MPT_WALKING_L3    = 3'd1,
    MPT_WALKING_L2    = 3'd2,
    MPT_WALKING_L1    = 3'd3,
    MPT_WALKING_L0    = 3'd4,
    MPT_WALKING_SKIP  = 3'd5
  } mpt_walking_t;

  typedef enum logic [1:0] {
    NO_ERROR         = 2'd0,
    PTE_FORMAT_ERROR = 2'd1,
    SPA_RANGE_ERROR  = 2'd2
  } mpt_format_error_t;

  typedef struct packed {
    logic                   valid;
    logic [MPTW_ID_W-1:0]   id;
    logic [63:0]            spa;
    access_type_t           access_type;
    mmpt_t                  mmpt;
    logic [63:0]            mpte;
    logic                   plb_hit;
    logic                   completed;
    logic                   access_error;
    mpt_walking_t           walking;
    mpt_format_error_t      format_error;
  } mptw_transaction_t;

  // True when any address bit above the implemented physical range is set.
  function automatic logic spa_out_of_range(input logic [63:0] spa, input int pa_width);
    logic [63:0] hi_mask;
    hi_mask = (pa_width >= 64) ? 64'd0 : ~((64'd1 << pa_width) - 64'd1);
    return |(spa & hi_mask);
  endfunction

endpackage

// File: rtl/pipeline_register.sv
// One-entry valid/ready register slice; accepts a new word whenever empty or draining.
module pipeline_register #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;

  assign in_ready  = !vld_p1 || out_ready;
  assign out_valid = vld_p1;
  assign out_data  = data_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  // Payload is only meaningful under vld_p1, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      data_p1 <= in_data;
    end
  end

endmodule

// File: rtl/mptw_request_stage.sv
// Front stage of the MPT walker: admits checker requests under a credit limit,
// tags them with a wrapping id and pre-classifies skip/range-error cases.
module mptw_request_stage
  import mpt_pkg::*;
#(
  parameter int PIPELINE_MASTER_DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING            = 4,
  parameter int PA_WIDTH                   = 56
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [63:0]                           req_spa_i,
  input  access_type_t                          req_access_type_i,
  input  mmpt_t                                 mmpt_i,
  input  logic                                  retire_i,
  output logic                                  stage_master_valid,
  input  logic                                  stage_master_ready,
  output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] stage_master_data,
  output logic [$clog2(MAX_OUTSTANDING):0]      outstanding_o
);

  localparam int ID_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [ID_W-1:0]  ID_LAST = ID_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16 ||
      (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_max_outstanding
    $error("MAX_OUTSTANDING must be a power of two in 1..16");
  end

  logic [ID_W-1:0]                       id_q;
  logic [CNT_W-1:0]                      outstanding_q;
  logic                                  credit_ok;
  logic                                  reg_in_ready;
  logic                                  accept;
  logic                                  retire_ok;
  mptw_transaction_t                     txn_p0;
  logic                                  vld_p0;
  logic [PIPELINE_MASTER_DATA_WIDTH-1:0] data_p0;

  // Range error outranks BARE; both bypass the walk but still hold an id and a credit.
  function automatic mptw_transaction_t build_txn(
    input logic [63:0]          spa,
    input access_type_t         access_type,
    input mmpt_t                mmpt,
    input logic [MPTW_ID_W-1:0] id
  );
    mptw_transaction_t t;
    t              = '0;
    t.valid        = 1'b1;
    t.id           = id;
    t.spa          = spa;
    t.access_type  = access_type;
    t.mmpt         = mmpt;
    t.walking      = MPT_WALKING_START;
    t.format_error = NO_ERROR;
    if (spa_out_of_range(spa, PA_WIDTH)) begin
      t.format_error = SPA_RANGE_ERROR;
      t.walking      = MPT_WALKING_SKIP;
      t.completed    = 1'b1;
    end else if (mmpt.mode == MPT_MODE_BARE) begin
      t.walking      = MPT_WALKING_SKIP;
      t.completed    = 1'b1;
      t.access_error = 1'b0;
    end
    return t;
  endfunction

  assign credit_ok   = outstanding_q < CNT_MAX;
  assign req_ready_o = !rst_i && reg_in_ready && credit_ok;
  assign accept      = req_valid_i && req_ready_o;
  assign retire_ok   = retire_i && (outstanding_q != '0);

  // Stage p0: classify the incoming request
  assign vld_p0  = req_valid_i && credit_ok;
  assign txn_p0  = build_txn(req_spa_i, req_access_type_i, mmpt_i, MPTW_ID_W'(id_q));
  assign data_p0 = PIPELINE_MASTER_DATA_WIDTH'(txn_p0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q          <= '0;
      outstanding_q <= '0;
    end else begin
      if (accept) begin
        id_q <= (id_q == ID_LAST) ? '0 : id_q + ID_W'(1);
      end
      if (accept && !retire_ok) begin
        outstanding_q <= outstanding_q + CNT_W'(1);
      end else if (!accept && retire_ok) begin
        outstanding_q <= outstanding_q - CNT_W'(1);
      end
    end
  end

  assign outstanding_o = outstanding_q;

  // Stage p1: output register towards the PLB lookup stage
  pipeline_register #(
    .DATA_W (PIPELINE_MASTER_DATA_WIDTH)
  ) u_out_reg (
    .clk       (clk_i),
    .rst       (rst_i),
    .in_valid  (vld_p0),
    .in_ready  (reg_in_ready),
    .in_data   (data_p0),
    .out_valid (stage_master_valid),
    .out_ready (stage_master_ready),
    .out_data  (stage_master_data)
  );

endmodule

// File: tb/tb_mptw_request_stage.sv
// Directed bench for mptw_request_stage with a queue-based reference model.
module tb_mptw_request_stage;
  import mpt_pkg::*;

  localparam int MAX_OUT = 4;
  localparam int PA_W    = 56;
  localparam int TW      = $bits(mptw_transaction_t);

  logic                      clk = 1'b0;
  logic                      rst_i;
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [63:0]               req_spa_i;
  access_type_t              req_access_type_i;
  mmpt_t                     mmpt_i;
  logic                      retire_i;
  logic                      stage_master_valid;
  logic                      stage_master_ready;
  logic [TW-1:0]             stage_master_data;
  logic [$clog2(MAX_OUT):0]  outstanding_o;

  always #5 clk = ~clk;

  mptw_request_stage #(
    .PIPELINE_MASTER_DATA_WIDTH (TW),
    .MAX_OUTSTANDING            (MAX_OUT),
    .PA_WIDTH                   (PA_W)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_spa_i          (req_spa_i),
    .req_access_type_i  (req_access_type_i),
    .mmpt_i             (mmpt_i),
    .retire_i           (retire_i),
    .stage_master_valid (stage_master_valid),
    .stage_master_ready (stage_master_ready),
    .stage_master_data  (stage_master_data),
    .outstanding_o      (outstanding_o)
  );

  int n_vec = 0;
  int n_bad = 0;
  mptw_transaction_t exp_q[$];
  int m_out;
  int m_id;

  function automatic mptw_transaction_t expect_txn(input logic [63:0] spa, input access_type_t acc,
                                                   input mmpt_t m, input int id);
    mptw_transaction_t t;
    t              = '0;
    t.valid        = 1'b1;
    t.id           = 4'(id);
    t.spa          = spa;
    t.access_type  = acc;
    t.mmpt         = m;
    t.walking      = MPT_WALKING_START;
    t.format_error = NO_ERROR;
    if ((spa >> PA_W) != 64'd0) begin
      t.format_error = SPA_RANGE_ERROR;
      t.walking      = MPT_WALKING_SKIP;
      t.completed    = 1'b1;
    end else if (m.mode == MPT_MODE_BARE) begin
      t.walking      = MPT_WALKING_SKIP;
      t.completed    = 1'b1;
    end
    return t;
  endfunction

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare DUT against the model at the falling edge, then advance the model.
  task automatic sample();
    bit exp_vld;
    bit exp_rdy;
    bit acc;
    bit ret;
    @(negedge clk);
    if (rst_i) begin
      exp_q.delete();
      m_out = 0;
      m_id  = 0;
    end
    exp_vld = exp_q.size() > 0;
    exp_rdy = !rst_i && (!exp_vld || stage_master_ready) && (m_out < MAX_OUT);
    check("valid", TW'(stage_master_valid), TW'(exp_vld));
    check("req_ready", TW'(req_ready_o), TW'(exp_rdy));
    check("outstanding", TW'(outstanding_o), TW'(m_out));
    if (exp_vld) check("data", stage_master_data, exp_q[0]);
    if (!rst_i) begin
      acc = req_valid_i && exp_rdy;
      ret = retire_i && (m_out > 0);
      if (exp_vld && stage_master_ready) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(expect_txn(req_spa_i, req_access_type_i, mmpt_i, m_id % MAX_OUT));
        m_id++;
      end
      if (acc && !ret) m_out++;
      else if (!acc && ret) m_out--;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  initial begin
    mptw_transaction_t got;
    int ids_a[6] = '{0, 1, 2, 3, 0, 1};
    rst_i              = 1'b1;
    req_valid_i        = 1'b0;
    req_spa_i          = 64'd0;
    req_access_type_i  = ACCESS_READ;
    mmpt_i.mode        = MPT_MODE_SMMPT43;
    mmpt_i.ppn         = 44'h0_0abc_1234;
    retire_i           = 1'b0;
    stage_master_ready = 1'b1;
    m_out = 0;
    m_id  = 0;

    sample();
    check("rst_valid", TW'(stage_master_valid), TW'(0));
    check("rst_ready", TW'(req_ready_o), TW'(0));
    check("rst_outstanding", TW'(outstanding_o), TW'(0));
    advance();
    rst_i = 1'b0;
    step();
    step();

    // back-to-back with retire from the third cycle
    for (int k = 0; k < 8; k++) begin
      req_valid_i       = (k < 6);
      req_spa_i         = 64'(k + 1) << 12;
      req_access_type_i = access_type_t'(2'(k % 3));
      retire_i          = (k >= 2);
      sample();
      if (k >= 1 && k <= 6) begin
        got = stage_master_data;
        check("b2b_valid", TW'(stage_master_valid), TW'(1));
        check("b2b_id", TW'(got.id), TW'(ids_a[k-1]));
      end
      advance();
    end
    retire_i    = 1'b0;
    req_valid_i = 1'b0;
    sample();
    check("b2b_drained", TW'(outstanding_o), TW'(0));
    advance();

    // credit exhaustion
    req_valid_i       = 1'b1;
    req_spa_i         = 64'h2_0000;
    req_access_type_i = ACCESS_READ;
    for (int k = 0; k < 4; k++) step();
    sample();
    check("credit_full_ready", TW'(req_ready_o), TW'(0));
    check("credit_full_count", TW'(outstanding_o), TW'(4));
    advance();
    retire_i = 1'b1;
    sample();
    check("credit_retire_cycle_ready", TW'(req_ready_o), TW'(0));
    advance();
    retire_i = 1'b0;
    sample();
    check("credit_after_retire_ready", TW'(req_ready_o), TW'(1));
    check("credit_after_retire_count", TW'(outstanding_o), TW'(3));
    advance();
    req_valid_i = 1'b0;
    sample();
    got = stage_master_data;
    check("credit_next_id", TW'(got.id), TW'(2));
    advance();
    retire_i = 1'b1;
    for (int k = 0; k < 4; k++) step();
    retire_i = 1'b0;

    // backpressure with a held request
    stage_master_ready = 1'b0;
    req_valid_i        = 1'b1;
    req_spa_i          = 64'h8000_1000;
    req_access_type_i  = ACCESS_WRITE;
    step();
    for (int k = 0; k < 3; k++) begin
      sample();
      got = stage_master_data;
      check("bp_spa", TW'(got.spa), TW'(64'h8000_1000));
      check("bp_id", TW'(got.id), TW'(3));
      check("bp_ready", TW'(req_ready_o), TW'(0));
      advance();
    end
    stage_master_ready = 1'b1;
    sample();
    check("bp_release_ready", TW'(req_ready_o), TW'(1));
    advance();
    req_valid_i = 1'b0;
    sample();
    got = stage_master_data;
    check("bp_second_id", TW'(got.id), TW'(0));
    advance();
    sample();
    check("bp_outstanding", TW'(outstanding_o), TW'(2));
    advance();

    // simultaneous accept and retire at outstanding=2
    req_valid_i = 1'b1;
    retire_i    = 1'b1;
    req_spa_i   = 64'h4000;
    step();
    req_valid_i = 1'b0;
    retire_i    = 1'b0;
    sample();
    check("sim_outstanding", TW'(outstanding_o), TW'(2));
    advance();

    // range error, BARE, non-BARE
    req_valid_i = 1'b1;
    retire_i    = 1'b1;
    req_spa_i   = 64'h0100_0000_0000_0000;
    step();
    req_spa_i   = 64'h1000;
    mmpt_i.mode = MPT_MODE_BARE;
    sample();
    got = stage_master_data;
    check("range_ferr", TW'(got.format_error), TW'(SPA_RANGE_ERROR));
    check("range_walk", TW'(got.walking), TW'(MPT_WALKING_SKIP));
    check("range_completed", TW'(got.completed), TW'(1));
    advance();
    mmpt_i.mode = MPT_MODE_SMMPT43;
    sample();
    got = stage_master_data;
    check("bare_walk", TW'(got.walking), TW'(MPT_WALKING_SKIP));
    check("bare_completed", TW'(got.completed), TW'(1));
    check("bare_ferr", TW'(got.format_error), TW'(NO_ERROR));
    advance();
    req_valid_i = 1'b0;
    retire_i    = 1'b0;
    sample();
    got = stage_master_data;
    check("nonbare_walk", TW'(got.walking), TW'(MPT_WALKING_START));
    check("nonbare_completed", TW'(got.completed), TW'(0));
    advance();

    // reset in the middle of a stall
    stage_master_ready = 1'b0;
    req_valid_i        = 1'b1;
    req_spa_i          = 64'h2000;
    step();
    req_valid_i = 1'b0;
    step();
    step();
    rst_i = 1'b1;
    sample();
    check("midrst_valid", TW'(stage_master_valid), TW'(0));
    check("midrst_ready", TW'(req_ready_o), TW'(0));
    check("midrst_outstanding", TW'(outstanding_o), TW'(0));
    advance();
    rst_i              = 1'b0;
    stage_master_ready = 1'b1;
    req_valid_i        = 1'b1;
    req_spa_i          = 64'h3000;
    step();
    req_valid_i = 1'b0;
    sample();
    got = stage_master_data;
    check("postrst_valid", TW'(stage_master_valid), TW'(1));
    check("postrst_id", TW'(got.id), TW'(0));
    advance();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
